// File: rtl/miner_work_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : miner_work_ctrl
// Purpose  : Job sequencer for a bank of SHA-256 hasher chains. It latches a
//            job (midstate + 96-bit header tail) and hands each core a fresh
//            nonce once per issue slot. It tracks which results in flight
//            belong to the current job and queues golden nonces, which are
//            hashes whose top word is zero, in a small FWFT FIFO.
// Ports    : hash_clk        - sole clock, rising edge
//            reset           - asynchronous, active-high
//            work_valid/ready/midstate/data - job offer handshake
//            core_state      - registered midstate broadcast to all cores
//            core_data       - per-core {nonce, data96}, core k in slice k
//            core_cnt/core_feedback - shared loop round counter / flag
//            core_hash_hi    - top word of each core's second hash
//            gn_valid/ready/nonce - golden-nonce FIFO read port
//            job_busy        - job running or draining
//            gn_overflow     - sticky: a golden nonce was dropped
// Revision : 1.0 - initial release
// ============================================================================
module miner_work_ctrl #(
  parameter int NUM_CORES    = 2,
  parameter int LOOP_LOG2    = 1,
  parameter int HASH_LATENCY = 132,
  parameter int GN_DEPTH     = 8
) (
  input  logic                      hash_clk,
  input  logic                      reset,
  input  logic                      work_valid,
  output logic                      work_ready,
  input  logic [255:0]              work_midstate,
  input  logic [95:0]               work_data,
  output logic [255:0]              core_state,
  output logic [128*NUM_CORES-1:0]  core_data,
  output logic [5:0]                core_cnt,
  output logic                      core_feedback,
  input  logic [32*NUM_CORES-1:0]   core_hash_hi,
  output logic                      gn_valid,
  input  logic                      gn_ready,
  output logic [31:0]               gn_nonce,
  output logic                      job_busy,
  output logic                      gn_overflow
);

  localparam int          c_LOOP     = 1 << LOOP_LOG2;
  localparam logic [5:0]  c_LAST_CNT = 6'(c_LOOP - 1);
  localparam logic [31:0] c_NC       = 32'(NUM_CORES);
  // Last nonce base: the largest multiple of NUM_CORES not above 2^32-NUM_CORES,
  // so the final slot never wraps past 32'hFFFFFFFF.
  localparam logic [63:0] c_SPAN     = 64'h1_0000_0000 - 64'(NUM_CORES);
  localparam logic [63:0] c_TERM64   = (c_SPAN / 64'(NUM_CORES)) * 64'(NUM_CORES);
  localparam logic [31:0] c_TERM_NB  = c_TERM64[31:0];
  localparam int          c_AW       = $clog2(GN_DEPTH);
  localparam int          c_DW       = $clog2(HASH_LATENCY + 1);
  localparam logic [c_AW:0]   c_PTR_ONE   = (c_AW + 1)'(1);
  localparam logic [c_DW-1:0] c_DRAIN_ONE = c_DW'(1);
  localparam logic [c_DW-1:0] c_DRAIN_TOP = c_DW'(HASH_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [31:0]                r_nb;
  logic [31:0]                w_nb_nxt;
  logic [31:0]                r_chk_nb;
  logic [95:0]                r_data96;
  logic [5:0]                 r_cnt;
  logic [c_DW-1:0]            r_drain;
  logic [HASH_LATENCY-1:0]    r_vline;
  logic [HASH_LATENCY-1:0]    w_vline_shift;
  logic [255:0]               r_core_state;
  logic [128*NUM_CORES-1:0]   r_core_data;
  logic [128*NUM_CORES-1:0]   w_core_data_cand;
  logic [31:0]                r_mem [GN_DEPTH];
  logic [c_AW:0]              r_wr_ptr;
  logic [c_AW:0]              r_rd_ptr;
  logic                       r_ovf;

  logic                       w_accept;
  logic                       w_issue;
  logic                       w_last_slot;
  logic                       w_drain_done;
  logic                       w_line_out;
  logic [NUM_CORES-1:0]       w_hit;
  logic [NUM_CORES-1:0]       w_hit_m1;
  logic                       w_hit_any;
  logic                       w_multi;
  logic [31:0]                w_hit_idx;
  logic [31:0]                w_push_nonce;
  logic                       w_empty;
  logic                       w_full;
  logic                       w_pop;
  logic                       w_push;

  assign work_ready   = ~reset;
  assign w_accept     = work_valid & work_ready;
  // An accepting cycle never issues for the outgoing job.
  assign w_issue      = (r_state == S_RUN) && (r_cnt == 6'd0) && !w_accept;
  assign w_last_slot  = w_issue && (r_nb == c_TERM_NB);
  assign w_drain_done = (r_state == S_DRAIN) && (r_drain == '0);
  assign w_nb_nxt     = w_accept ? 32'h0 : (w_issue ? r_nb + c_NC : r_nb);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    job_busy    = (r_state != S_IDLE);
    if (w_accept) begin
      w_state_nxt = S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (w_last_slot)  w_state_nxt = S_DRAIN;
        S_DRAIN: if (w_drain_done) w_state_nxt = S_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // ------------------------------------------------------- valid shift line
  generate
    if (HASH_LATENCY == 1) begin : g_vline_one
      assign w_vline_shift = w_issue;
    end else begin : g_vline_deep
      assign w_vline_shift = {r_vline[HASH_LATENCY-2:0], w_issue};
    end
  endgenerate

  assign w_line_out = r_vline[HASH_LATENCY-1];

  // ------------------------------------------------ per-core data and hits
  always_comb begin
    w_core_data_cand = '0;
    w_hit            = '0;
    w_hit_idx        = 32'h0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_core_data_cand[128*k +: 128] = {r_nb + 32'(k), r_data96};
      w_hit[k] = w_line_out && (core_hash_hi[32*k +: 32] == 32'h0);
    end
    // Descending scan so the lowest-numbered hitting core wins.
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (w_hit[k]) w_hit_idx = 32'(k);
    end
  end

  assign w_hit_any    = |w_hit;
  // Clearing the lowest set bit leaves something only if two or more cores hit.
  assign w_hit_m1     = w_hit - NUM_CORES'(1);
  assign w_multi      = |(w_hit & w_hit_m1);
  assign w_push_nonce = r_chk_nb + w_hit_idx;

  // ------------------------------------------------------- golden FIFO
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_pop    = !w_empty && gn_ready;
  assign w_push   = w_hit_any && (!w_full || w_pop);
  assign gn_valid = !w_empty;
  assign gn_nonce = w_empty ? 32'h0 : r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge hash_clk) begin
    if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= w_push_nonce;
  end

  // ------------------------------------------------------- datapath
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      r_nb         <= 32'h0;
      r_chk_nb     <= 32'h0;
      r_data96     <= 96'h0;
      r_cnt        <= 6'd0;
      r_drain      <= '0;
      r_vline      <= '0;
      r_core_state <= 256'h0;
      r_core_data  <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_ovf        <= 1'b0;
    end else begin
      // Written every cycle so the nonce base always reloads from itself.
      r_nb <= w_nb_nxt;

      if (w_accept) begin
        r_core_state <= work_midstate;
        r_data96     <= work_data;
      end

      if (w_accept || r_state == S_IDLE || w_drain_done || r_cnt == c_LAST_CNT) begin
        r_cnt <= 6'd0;
      end else begin
        r_cnt <= r_cnt + 6'd1;
      end

      if (w_last_slot) begin
        r_drain <= c_DRAIN_TOP;
      end else if (r_state == S_DRAIN && r_drain != '0) begin
        r_drain <= r_drain - c_DRAIN_ONE;
      end

      if (w_issue) r_core_data <= w_core_data_cand;

      // Preemption flushes everything in flight for the old job.
      r_vline <= w_accept ? '0 : w_vline_shift;

      // Results leave the line in issue order, so a counter stepping once per
      // checked result recovers the nonce base of the slot being checked.
      if (w_accept) begin
        r_chk_nb <= 32'h0;
      end else if (w_line_out) begin
        r_chk_nb <= r_chk_nb + c_NC;
      end

      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;

      if (w_multi || (w_hit_any && !w_push)) r_ovf <= 1'b1;
    end
  end

  assign core_state    = r_core_state;
  assign core_data     = r_core_data;
  assign core_cnt      = r_cnt;
  assign core_feedback = (r_cnt != 6'd0);
  assign gn_overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_miner_work_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_miner_work_ctrl
// Purpose  : Self-checking bench for miner_work_ctrl (2 cores, loop of 2,
//            latency 8, FIFO depth 4). A directed vector table, hand-written
//            sequences for preemption and nonce-space exhaustion, and a
//            randomized run against a slot-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_miner_work_ctrl;

  localparam int N     = 2;
  localparam int LOOP  = 2;
  localparam int LAT   = 8;
  localparam int DEPTH = 4;

  logic                 hash_clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 work_valid = 1'b0;
  logic                 work_ready;
  logic [255:0]         work_midstate = '0;
  logic [95:0]          work_data = '0;
  logic [255:0]         core_state;
  logic [128*N-1:0]     core_data;
  logic [5:0]           core_cnt;
  logic                 core_feedback;
  logic [32*N-1:0]      core_hash_hi = '1;
  logic                 gn_valid;
  logic                 gn_ready = 1'b0;
  logic [31:0]          gn_nonce;
  logic                 job_busy;
  logic                 gn_overflow;

  miner_work_ctrl #(
    .NUM_CORES(N), .LOOP_LOG2(1), .HASH_LATENCY(LAT), .GN_DEPTH(DEPTH)
  ) dut (
    .hash_clk(hash_clk), .reset(reset),
    .work_valid(work_valid), .work_ready(work_ready),
    .work_midstate(work_midstate), .work_data(work_data),
    .core_state(core_state), .core_data(core_data),
    .core_cnt(core_cnt), .core_feedback(core_feedback),
    .core_hash_hi(core_hash_hi),
    .gn_valid(gn_valid), .gn_ready(gn_ready), .gn_nonce(gn_nonce),
    .job_busy(job_busy), .gn_overflow(gn_overflow)
  );

  always #5 hash_clk = ~hash_clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rst;
    logic        wv;
    logic [1:0]  z;     // bit k set: core k reports a zero top word
    logic        rdy;
    logic        gv;
    logic [31:0] gnn;
    logic        ovf;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic wv, input logic [1:0] z,
                              input logic rdy, input logic gv, input logic [31:0] gnn,
                              input logic ovf, input logic busy);
    vec_t v;
    v.rst = rst; v.wv = wv; v.z = z; v.rdy = rdy;
    v.gv = gv; v.gnn = gnn; v.ovf = ovf; v.busy = busy;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic drive_z(input logic [1:0] z);
    for (int k = 0; k < N; k++) core_hash_hi[32*k +: 32] = z[k] ? 32'h0 : 32'hFFFF_FFFF;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1; work_valid = 1'b0; gn_ready = 1'b0; drive_z(2'b00);
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] nonce_of(input int k);
    return core_data[128*k + 96 +: 32];
  endfunction

  // Reference model state for the randomized run
  int          m_a;
  bit          m_active;
  bit          m_cd_valid;
  logic [31:0] m_base;
  logic [31:0] m_q[$];
  bit          m_ovf;

  initial begin
    // -------------------------------------------------- directed table
    // Job 1 accepted at row 1; slot j is checked at row 1+9+2j.
    add(1,0,2'b00,0, 0,0,0,0);
    add(0,1,2'b00,0, 0,0,0,0);
    for (int i = 2; i <= 15; i++)
      add(0,0,(i==3 || i==11 || i==13 || i==15) ? 2'b11 : 2'b00,0, 0,0,0,1);
    add(0,0,2'b10,0, 0,0,0,1);          // slot nb=6, core 1 hits -> 7
    add(0,0,2'b00,0, 1,7,0,1);
    add(0,0,2'b11,0, 1,7,0,1);          // both cores hit -> 8, overflow
    add(0,0,2'b00,1, 1,7,1,1);
    add(0,0,2'b00,1, 1,8,1,1);
    add(0,0,2'b00,0, 0,0,1,1);
    add(1,0,2'b00,0, 0,0,0,0);          // reset clears sticky overflow
    add(0,1,2'b00,0, 0,0,0,0);          // job 2 accepted at row 23
    for (int i = 24; i <= 31; i++) add(0,0,2'b00,0, 0,0,0,1);
    add(0,0,2'b01,0, 0,0,0,1);          // push 0
    add(0,0,2'b00,0, 1,0,0,1);
    add(0,0,2'b01,0, 1,0,0,1);          // push 2
    add(0,0,2'b00,0, 1,0,0,1);
    add(0,0,2'b01,0, 1,0,0,1);          // push 4
    add(0,0,2'b00,0, 1,0,0,1);
    add(0,0,2'b01,0, 1,0,0,1);          // push 6 -> full
    add(0,0,2'b00,0, 1,0,0,1);
    add(0,0,2'b01,0, 1,0,0,1);          // 8 dropped
    add(0,0,2'b00,0, 1,0,1,1);
    add(0,0,2'b10,1, 1,0,1,1);          // push 11 with pop while full
    add(0,0,2'b00,1, 1,2,1,1);
    add(0,0,2'b00,1, 1,4,1,1);
    add(0,0,2'b00,1, 1,6,1,1);
    add(0,0,2'b00,1, 1,11,1,1);
    add(0,0,2'b00,0, 0,0,1,1);
    add(0,0,2'b01,1, 0,0,1,1);          // push into empty with ready high -> 16
    add(0,0,2'b00,0, 1,16,1,1);
    add(0,0,2'b00,0, 1,16,1,1);

    foreach (tbl[i]) begin
      tick();
      reset = tbl[i].rst; work_valid = tbl[i].wv; gn_ready = tbl[i].rdy;
      drive_z(tbl[i].z);
      #1;
      chk($sformatf("row%0d work_ready", i), 32'(work_ready), 32'(!tbl[i].rst));
      chk($sformatf("row%0d gn_valid", i), 32'(gn_valid), 32'(tbl[i].gv));
      chk($sformatf("row%0d gn_nonce", i), gn_nonce, tbl[i].gnn);
      chk($sformatf("row%0d gn_overflow", i), 32'(gn_overflow), 32'(tbl[i].ovf));
      chk($sformatf("row%0d job_busy", i), 32'(job_busy), 32'(tbl[i].busy));
      if (tbl[i].rst) begin
        chk($sformatf("row%0d rst core_cnt", i), 32'(core_cnt), 32'h0);
        chk($sformatf("row%0d rst feedback", i), 32'(core_feedback), 32'h0);
        chk($sformatf("row%0d rst core_state", i), 32'(|core_state), 32'h0);
        chk($sformatf("row%0d rst core_data", i), 32'(|core_data), 32'h0);
      end
    end

    // ------------------------------- nonce sequence and preemption
    do_reset();
    tick();
    work_valid = 1'b1; work_midstate = {8{32'hA5A5_0001}}; work_data = 96'h1234;
    for (int r = 1; r <= 5; r++) begin
      tick();
      work_valid = 1'b0;
      #1;
      chk($sformatf("seqA r%0d core_cnt", r), 32'(core_cnt), 32'((r-1) % LOOP));
      chk($sformatf("seqA r%0d feedback", r), 32'(core_feedback), 32'(((r-1) % LOOP) != 0));
      chk($sformatf("seqA r%0d core_state", r), core_state[31:0], 32'hA5A5_0001);
      if (r >= 2) begin
        chk($sformatf("seqA r%0d nonce0", r), nonce_of(0), 32'(N*((r-2)/LOOP)));
        chk($sformatf("seqA r%0d nonce1", r), nonce_of(1), 32'(N*((r-2)/LOOP) + 1));
        chk($sformatf("seqA r%0d data96", r), core_data[31:0], 32'h1234);
      end
    end
    tick();
    work_valid = 1'b1; work_midstate = {8{32'h5A5A_0002}}; work_data = 96'h5678;
    drive_z(2'b11);
    for (int r = 1; r <= 8; r++) begin
      tick();
      work_valid = 1'b0; drive_z(2'b11);
      #1;
      chk($sformatf("preempt r%0d gn_valid", r), 32'(gn_valid), 32'h0);
      chk($sformatf("preempt r%0d core_cnt", r), 32'(core_cnt), 32'((r-1) % LOOP));
      if (r >= 2) begin
        chk($sformatf("preempt r%0d nonce0", r), nonce_of(0), 32'(N*((r-2)/LOOP)));
        chk($sformatf("preempt r%0d nonce1", r), nonce_of(1), 32'(N*((r-2)/LOOP) + 1));
      end
    end
    tick();
    drive_z(2'b00);
    #1;
    chk("preempt r9 gn_valid", 32'(gn_valid), 32'h0);
    chk("preempt core_state", core_state[31:0], 32'h5A5A_0002);
    tick();
    #1;
    chk("preempt r10 gn_valid", 32'(gn_valid), 32'h0);
    chk("preempt r10 gn_overflow", 32'(gn_overflow), 32'h0);

    // ------------------------------- end of nonce space
    do_reset();
    tick();
    work_valid = 1'b1;
    tick();
    work_valid = 1'b0;
    tick();                                   // r=2, non-issue round
    force dut.r_nb = 32'hFFFF_FFFC;
    tick();                                   // r=3, issue slot
    release dut.r_nb;
    #1;
    chk("wrap r3 core_cnt", 32'(core_cnt), 32'h0);
    tick();                                   // r=4
    chk("wrap r4 nonce0", nonce_of(0), 32'hFFFF_FFFC);
    chk("wrap r4 nonce1", nonce_of(1), 32'hFFFF_FFFD);
    chk("wrap r4 busy", 32'(job_busy), 32'h1);
    for (int r = 5; r <= 17; r++) begin
      tick();
      if (r >= 6) begin
        chk($sformatf("wrap r%0d nonce0", r), nonce_of(0), 32'hFFFF_FFFE);
        chk($sformatf("wrap r%0d nonce1", r), nonce_of(1), 32'hFFFF_FFFF);
      end
      chk($sformatf("wrap r%0d busy", r), 32'(job_busy), 32'(r <= 13));
      if (r >= 14) begin
        chk($sformatf("wrap r%0d core_cnt", r), 32'(core_cnt), 32'h0);
        chk($sformatf("wrap r%0d feedback", r), 32'(core_feedback), 32'h0);
      end
    end
    chk("wrap r17 gn_valid", 32'(gn_valid), 32'h0);

    // ------------------------------- randomized run vs reference model
    do_reset();
    m_active = 0; m_cd_valid = 0; m_base = 0; m_ovf = 0; m_a = 0;
    m_q.delete();
    for (int c = 0; c < 500; c++) begin
      logic [1:0] zm;
      bit         pop;
      tick();
      work_valid = (c == 0) || ($urandom_range(0, 59) == 0);
      for (int k = 0; k < N; k++)
        core_hash_hi[32*k +: 32] = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom | 32'h1);
      gn_ready = ($urandom_range(0, 2) == 0);
      #1;
      if (m_active && c >= m_a + 2) begin
        m_base = 32'(N * ((c - m_a - 2) / LOOP));
        m_cd_valid = 1;
      end
      chk($sformatf("rnd c%0d work_ready", c), 32'(work_ready), 32'h1);
      chk($sformatf("rnd c%0d busy", c), 32'(job_busy), 32'(m_active));
      chk($sformatf("rnd c%0d core_cnt", c), 32'(core_cnt),
          m_active ? 32'((c - m_a - 1) % LOOP) : 32'h0);
      chk($sformatf("rnd c%0d gn_valid", c), 32'(gn_valid), 32'(m_q.size() != 0));
      chk($sformatf("rnd c%0d gn_nonce", c), gn_nonce, (m_q.size() != 0) ? m_q[0] : 32'h0);
      chk($sformatf("rnd c%0d gn_overflow", c), 32'(gn_overflow), 32'(m_ovf));
      for (int k = 0; k < N; k++)
        chk($sformatf("rnd c%0d nonce%0d", c, k), nonce_of(k),
            m_cd_valid ? m_base + 32'(k) : 32'h0);

      // Model update for this cycle's inputs
      pop = (m_q.size() != 0) && gn_ready;
      zm  = '0;
      if (m_active && (c - m_a - 1 - LAT) >= 0 && ((c - m_a - 1 - LAT) % LOOP) == 0) begin
        for (int k = 0; k < N; k++) zm[k] = (core_hash_hi[32*k +: 32] == 32'h0);
      end
      if (pop) void'(m_q.pop_front());
      if (zm != 0) begin
        int j;
        int kl;
        j  = (c - m_a - 1 - LAT) / LOOP;
        kl = zm[0] ? 0 : 1;
        if (zm == 2'b11) m_ovf = 1;
        if (m_q.size() < DEPTH) m_q.push_back(32'(N * j + kl));
        else m_ovf = 1;
      end
      if (work_valid) begin
        m_active = 1;
        m_a = c;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
